// File: rtl/rt_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer, the ray-tracing core and the frame buffer.
// The master side is the sequencer; the slave side is the core plus the memory port.
interface rt_frame_sequencer_if #(
  parameter int ADDR_W = 17
);
  logic              rt_enable;
  logic [9:0]        rt_x;
  logic [8:0]        rt_y;
  logic              rt_ready;
  logic [3:0]        rt_pixel;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [15:0]       fb_data;
  logic              fb_ack;

  modport master (
    output rt_enable, rt_x, rt_y,
    input  rt_ready, rt_pixel,
    output fb_we, fb_addr, fb_data,
    input  fb_ack
  );

  modport slave (
    input  rt_enable, rt_x, rt_y,
    output rt_ready, rt_pixel,
    input  fb_we, fb_addr, fb_data,
    output fb_ack
  );
endinterface

// File: rtl/rt_frame_sequencer.sv
// Raster-scan request sequencer for the ray-tracing core: issues one request per pixel,
// packs four 4-bit shades per word and writes words out through a single-entry write slot.
//
//   state    | meaning
//   ST_IDLE  | waiting for frame start or for the issue condition
//   ST_ISSUE | one-cycle request pulse to the core
//   ST_ACK   | waiting for the core to drop READY (request accepted)
//   ST_WAIT  | waiting for READY to return; shade latched on that edge
module rt_frame_sequencer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 17
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 run_i,
  rt_frame_sequencer_if.master bus,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic [7:0]           frame_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              active_q;
  logic              all_issued_q;
  logic [9:0]        x_q;
  logic [8:0]        y_q;
  logic [ADDR_W-1:0] addr_q;
  logic [11:0]       pack_q;
  logic              slot_full_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [15:0]       fb_data_q;
  logic              frame_done_q;
  logic [7:0]        frame_count_q;

  logic issue_ok, latch, slot_ack, start, x_last, y_last;

  // A pixel that completes a word may only be issued into an empty slot, so a
  // completed word never has to wait for space.
  assign issue_ok = active_q && !all_issued_q && bus.rt_ready &&
                    ((x_q[1:0] != 2'd3) || !slot_full_q);
  assign latch    = (state_q == ST_WAIT) && bus.rt_ready;
  assign slot_ack = slot_full_q && bus.fb_ack;
  assign start    = (state_q == ST_IDLE) && !active_q && run_i;
  assign x_last   = (x_q == 10'(H_RES - 1));
  assign y_last   = (y_q == 9'(V_RES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (issue_ok)       state_d = ST_ISSUE;
      ST_ISSUE:                     state_d = ST_ACK;
      ST_ACK:   if (!bus.rt_ready)  state_d = ST_WAIT;
      ST_WAIT:  if (bus.rt_ready)   state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.rt_enable = (state_q == ST_ISSUE);
    bus.rt_x      = x_q;
    bus.rt_y      = y_q;
    bus.fb_we     = slot_full_q;
    bus.fb_addr   = fb_addr_q;
    bus.fb_data   = fb_data_q;
    busy_o        = active_q;
    frame_done_o  = frame_done_q;
    frame_count_o = frame_count_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q      <= 1'b0;
      all_issued_q  <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      pack_q        <= '0;
      slot_full_q   <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;

      if (start) begin
        active_q     <= 1'b1;
        all_issued_q <= 1'b0;
        x_q          <= '0;
        y_q          <= '0;
        addr_q       <= '0;
        pack_q       <= '0;
      end

      if (latch) begin
        unique case (x_q[1:0])
          2'd0: pack_q[3:0]  <= bus.rt_pixel;
          2'd1: pack_q[7:4]  <= bus.rt_pixel;
          2'd2: pack_q[11:8] <= bus.rt_pixel;
          default: begin
            slot_full_q <= 1'b1;
            fb_data_q   <= {bus.rt_pixel, pack_q};
            fb_addr_q   <= addr_q;
            addr_q      <= addr_q + 1'b1;
            pack_q      <= '0;
          end
        endcase

        if (x_last) begin
          x_q <= '0;
          if (y_last) all_issued_q <= 1'b1;
          else        y_q          <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end

      // The slot can only hold the final word once every pixel has been issued.
      if (slot_ack) begin
        slot_full_q <= 1'b0;
        if (all_issued_q) begin
          frame_done_q  <= 1'b1;
          frame_count_q <= frame_count_q + 1'b1;
          active_q      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rt_frame_sequencer.sv
// Directed walk through reset, request timing, packing, backpressure, full frames and
// mid-frame reset, with a random-latency core model and a raster/word reference model.
module tb_rt_frame_sequencer;
  localparam int H     = 8;
  localparam int V     = 2;
  localparam int AW    = 4;
  localparam int PIX   = H * V;
  localparam int WORDS = PIX / 4;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       run;
  logic       busy, frame_done;
  logic [7:0] frame_count;

  rt_frame_sequencer_if #(.ADDR_W(AW)) bus ();

  rt_frame_sequencer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_b),
    .run_i         (run),
    .bus           (bus),
    .busy_o        (busy),
    .frame_done_o  (frame_done),
    .frame_count_o (frame_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model state
  logic [3:0] returned [V][H];
  logic [3:0] forced [$];
  int  exp_idx = 0;
  int  exp_addr = 0;
  int  words_acked = 0;
  int  done_pulses = 0;
  bit  prev_en = 1'b0;
  bit  prev_done = 1'b0;

  // stimulus knobs
  int  core_lat = 5;
  bit  lat_rand = 1'b0;
  bit  ack_rand = 1'b0;
  bit  ack_level = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.fb_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.fb_ack = ack_rand ? 1'($urandom) : ack_level;
    end
  end

  // Core model: drops READY the cycle after the request, keeps it low for lat cycles.
  initial begin
    int cx, cy, lat;
    logic [3:0] px;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) returned[r][c] = 4'd0;
    bus.rt_ready = 1'b1;
    bus.rt_pixel = 4'd0;
    forever begin
      @(negedge clk);
      if (bus.rt_enable) begin
        cx  = int'(bus.rt_x);
        cy  = int'(bus.rt_y);
        px  = (forced.size() > 0) ? forced.pop_front() : 4'($urandom);
        lat = lat_rand ? int'($urandom_range(1, 6)) : core_lat;
        @(posedge clk);
        #1 bus.rt_ready = 1'b0;
        repeat (lat) @(posedge clk);
        #1;
        bus.rt_pixel = px;
        bus.rt_ready = 1'b1;
        if (cx < H && cy < V) returned[cy][cx] = px;
      end
    end
  end

  // Request monitor: raster order, never back-to-back, never while the core is busy.
  initial forever begin
    @(negedge clk);
    if (bus.rt_enable) begin
      chk("req_x", 32'(bus.rt_x), 32'(exp_idx % H));
      chk("req_y", 32'(bus.rt_y), 32'(exp_idx / H));
      chk("req_while_ready", 32'(bus.rt_ready), 32'd1);
      chk("req_back_to_back", 32'(prev_en), 32'd0);
      exp_idx = (exp_idx + 1) % PIX;
    end
    prev_en = bus.rt_enable;
  end

  // Write monitor: every accepted word matches the shades the core returned.
  initial forever begin
    int row, col;
    logic [15:0] word;
    @(negedge clk);
    if (rst_b && bus.fb_we && bus.fb_ack) begin
      row  = exp_addr / (H / 4);
      col  = (exp_addr % (H / 4)) * 4;
      word = {returned[row][col+3], returned[row][col+2], returned[row][col+1], returned[row][col]};
      chk("fb_addr", 32'(bus.fb_addr), 32'(exp_addr));
      chk("fb_data", 32'(bus.fb_data), 32'(word));
      exp_addr = (exp_addr + 1) % WORDS;
      words_acked++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (frame_done) begin
      done_pulses++;
      chk("done_single_pulse", 32'(prev_done), 32'd0);
    end
    prev_done = frame_done;
  end

  task automatic wait_en(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.rt_enable) begin found = 1'b1; break; end
    end
  endtask

  task automatic wait_we(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.fb_we) begin found = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_done) begin found = 1'b1; break; end
    end
  endtask

  initial begin
    bit found, bp_ok;
    int t0, ack_cyc, bp_reqs, wa0;
    logic [AW-1:0] hold_addr;
    logic [15:0]   hold_data;

    rst_b = 1'b0;
    run   = 1'b1;
    forced = '{4'd1, 4'd2, 4'd3, 4'd4};

    // reset held three cycles with RUN high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rt_enable", 32'(bus.rt_enable), 32'd0);
    chk("rst_rt_x", 32'(bus.rt_x), 32'd0);
    chk("rst_rt_y", 32'(bus.rt_y), 32'd0);
    chk("rst_fb_we", 32'(bus.fb_we), 32'd0);
    chk("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    chk("rst_fb_data", 32'(bus.fb_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);

    @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk("en_release_c0", 32'(bus.rt_enable), 32'd0);
    @(negedge clk);
    chk("en_release_c1", 32'(bus.rt_enable), 32'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    @(negedge clk);
    chk("en_release_c2", 32'(bus.rt_enable), 32'd1);
    t0 = cyc;

    // second request with L=5
    wait_en(40, found);
    chk("second_req_seen", 32'(found), 32'd1);
    chk("second_req_gap_ge8", 32'((cyc - t0) >= 8), 32'd1);
    chk("second_req_x", 32'(bus.rt_x), 32'd1);

    // packing of shades 1,2,3,4 with zero-wait memory
    wait_we(100, found);
    chk("pack_we_seen", 32'(found), 32'd1);
    chk("pack_addr", 32'(bus.fb_addr), 32'd0);
    chk("pack_data", 32'(bus.fb_data), 32'h4321);
    ack_level = 1'b0;
    @(negedge clk);
    chk("pack_we_one_cycle", 32'(bus.fb_we), 32'd0);

    // backpressure on the second word
    wait_we(100, found);
    chk("bp_we_seen", 32'(found), 32'd1);
    chk("bp_addr", 32'(bus.fb_addr), 32'd1);
    hold_addr = bus.fb_addr;
    hold_data = bus.fb_data;
    bp_ok = 1'b1;
    bp_reqs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.fb_we !== 1'b1 || bus.fb_addr !== hold_addr || bus.fb_data !== hold_data) bp_ok = 1'b0;
      if (bus.rt_enable) bp_reqs++;
    end
    chk("bp_slot_stable", 32'(bp_ok), 32'd1);
    chk("bp_reqs_during_stall", 32'(bp_reqs), 32'd3);
    ack_level = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.fb_ack) found = 1'b1;
    end
    ack_cyc = cyc;
    chk("bp_ack_seen", 32'(found), 32'd1);
    wait_en(40, found);
    chk("bp_resume_seen", 32'(found), 32'd1);
    chk("bp_resume_x", 32'(bus.rt_x), 32'd3);
    chk("bp_resume_y", 32'(bus.rt_y), 32'd1);
    chk("bp_resume_after_ack", 32'(cyc > ack_cyc), 32'd1);

    // rest of frame 1 with random acknowledge
    ack_rand = 1'b1;
    wait_done(500, found);
    chk("f1_done_seen", 32'(found), 32'd1);
    chk("f1_frame_count", 32'(frame_count), 32'd1);
    chk("f1_busy_clear", 32'(busy), 32'd0);
    chk("f1_words", 32'(words_acked), 32'(WORDS));
    @(negedge clk);
    chk("f1_done_dropped", 32'(frame_done), 32'd0);

    // frame 2 with random core latency
    lat_rand = 1'b1;
    wait_en(20, found);
    chk("f2_first_req_seen", 32'(found), 32'd1);
    chk("f2_first_x", 32'(bus.rt_x), 32'd0);
    chk("f2_first_y", 32'(bus.rt_y), 32'd0);
    wait_done(1000, found);
    chk("f2_done_seen", 32'(found), 32'd1);
    chk("f2_frame_count", 32'(frame_count), 32'd2);
    chk("f2_words", 32'(words_acked), 32'(2 * WORDS));

    // frame 3: reset while pixel (5,0) is in flight
    lat_rand = 1'b0;
    core_lat = 5;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      wait_en(60, found);
      if (found && !(bus.rt_x == 10'd5 && bus.rt_y == 9'd0)) found = 1'b0;
    end
    chk("mid_req_5_0_seen", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    exp_idx = 0;
    exp_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_fb_we", 32'(bus.fb_we), 32'd0);
    chk("mid_rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_frame_count", 32'(frame_count), 32'd0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    wa0 = words_acked;
    wait_en(60, found);
    chk("mid_restart_seen", 32'(found), 32'd1);
    chk("mid_restart_x", 32'(bus.rt_x), 32'd0);
    chk("mid_restart_y", 32'(bus.rt_y), 32'd0);
    wait_done(1000, found);
    run = 1'b0;
    chk("mid_done_seen", 32'(found), 32'd1);
    chk("mid_frame_count", 32'(frame_count), 32'd1);
    chk("mid_words", 32'(words_acked - wa0), 32'(WORDS));
    repeat (5) @(negedge clk);
    chk("idle_after_run_low", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed still running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
